aixh_mxc_upper_bwd_packer: RTL and testbench
============================================

AIXH_MXC_UPPER_BWD_PACKER -- requirements
Module: AIXH_MXC_UPPER_bwd_packer

Interface
REQ-001 SHALL have parameter DWIDTH, default 64: width of one backward beat from the upper array's left edge.
REQ-002 SHALL have parameter PACK, default 4: beats packed per output word (power of 2, >=2).
REQ-003 SHALL have parameter DEPTH, default 8: output FIFO depth in words (power of 2, >=2).
REQ-004 SHALL have parameter LEN_W, default 16: width of the frame length field.
REQ-005 SHALL have port aixh_core_clk2x, input, 1: the single clock; all state rises on its posedge.
REQ-006 SHALL have port aixh_core_rstn, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port i_start, input, 1: frame start pulse.
REQ-008 SHALL have port i_len, input, LEN_W: beats in the frame, sampled with i_start.
REQ-009 SHALL have port o_busy, output, 1: high whenever state != IDLE.
REQ-010 SHALL have port o_done, output, 1: one-cycle frame-complete pulse.
REQ-011 SHALL have port i_bwd_vld, input, 1: backward beat valid; no backpressure.
REQ-012 SHALL have port i_bwd_dat, input, DWIDTH: backward beat data.
REQ-013 SHALL have ports o_vld (output, 1), i_rdy (input, 1), o_dat (output, DWIDTH*PACK), o_keep (output, PACK) and o_last (output, 1) forming the packed valid/ready output.
REQ-014 SHALL have ports o_ovf (output, 1), the sticky overflow flag, and i_clr_ovf (input, 1), which clears o_ovf.

Function
REQ-015 SHALL implement states IDLE, RUN and DRAIN.
REQ-016 In IDLE, i_start with i_len>0 SHALL load the remaining-beat counter with i_len, clear the lane index and enter RUN.
REQ-017 In IDLE, i_start with i_len==0 SHALL pulse o_done in the next cycle, stay in IDLE and emit no word.
REQ-018 i_start outside IDLE SHALL be ignored.
REQ-019 i_bwd_vld in IDLE or DRAIN SHALL be dropped without effect.
REQ-020 In RUN, each beat SHALL be written to lane = lane index (lane 0 = o_dat[DWIDTH-1:0]); the lane index then increments mod PACK and the remaining count decrements.
REQ-021 A word SHALL be pushed on the beat that fills lane PACK-1 or on the beat where remaining==1, whichever comes first.
REQ-022 On a push, unfilled lanes SHALL read zero, o_keep bit i SHALL be set for filled lane i, and last SHALL equal (remaining==1).
REQ-023 The beat with remaining==1 SHALL move the block to DRAIN.
REQ-024 In DRAIN, once the FIFO is empty and no push is pending, the block SHALL pulse o_done for one cycle and return to IDLE.
REQ-025 The pushed word SHALL appear at o_vld in the cycle after its final beat is sampled.
REQ-026 o_dat, o_keep and o_last SHALL hold stable while o_vld=1 and i_rdy=0.
REQ-027 A pop SHALL occur when o_vld&i_rdy; words SHALL leave in FIFO order.
REQ-028 A push into a full FIFO without a simultaneous pop SHALL drop the word and set o_ovf; the counters and lane index still advance.
REQ-029 A push and a pop in the same cycle with the FIFO full SHALL both be accepted without overflow.
REQ-030 o_ovf SHALL stay set until i_clr_ovf=1; when a new overflow and i_clr_ovf occur in the same cycle, set SHALL win.
REQ-031 The remaining counter SHALL be LEN_W bits and SHALL never wrap below zero.

Reset
REQ-032 Asserting aixh_core_rstn=0 SHALL immediately force state IDLE, FIFO empty, counters 0, and o_vld, o_dat, o_keep, o_last, o_busy, o_done and o_ovf all 0, including mid-frame; any partial word SHALL be discarded.
REQ-033 After release, the first i_start SHALL be honoured.

Verification
REQ-034 PACK=4, len=8, beats 1..8 back-to-back, i_rdy=1 -> words {4,3,2,1} then {8,7,6,5}, keep=4'hF, o_last only on word 2, o_done 1 cycle after word 2 pops.
REQ-035 len=6, beats 1..6 -> word 2 = {0,0,6,5}, keep=4'b0011, o_last=1, then o_done.
REQ-036 len=0 -> o_done in the cycle after i_start, o_vld never asserted, o_busy stays 0.
REQ-037 i_rdy=0, len=40, DEPTH=8 -> 8 words stored, words 9-10 dropped, o_ovf=1; then i_rdy=1 -> 8 words drain in order, o_done pulses, o_ovf stays 1 until i_clr_ovf.
REQ-038 FIFO full with a pop in the same cycle as the 4th beat -> word accepted, o_ovf stays 0.
REQ-039 Reset pulsed after 3 beats of a len=8 frame -> all outputs 0; a fresh len=4 frame then yields one word, keep=4'hF, o_last=1.

Source files
------------

// File: rtl/aixh_mxc_upper_bwd_packer.sv
`default_nettype none
//============================================================================
// Module      : aixh_mxc_upper_bwd_packer
// Description : Packs PACK backward beats from the upper array's left edge
//               into one wide word, with a valid/ready output FIFO.
// Revision    : 1.0 - initial release
//============================================================================
module aixh_mxc_upper_bwd_packer #(
    parameter int DWIDTH = 64,
    parameter int PACK   = 4,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 16
) (
    input  logic                     aixh_core_clk2x,
    input  logic                     aixh_core_rstn,
    input  logic                     i_start,
    input  logic [LEN_W-1:0]         i_len,
    output logic                     o_busy,
    output logic                     o_done,
    input  logic                     i_bwd_vld,
    input  logic [DWIDTH-1:0]        i_bwd_dat,
    output logic                     o_vld,
    input  logic                     i_rdy,
    output logic [DWIDTH*PACK-1:0]   o_dat,
    output logic [PACK-1:0]          o_keep,
    output logic                     o_last,
    output logic                     o_ovf,
    input  logic                     i_clr_ovf
);

    localparam int c_lane_w = $clog2(PACK);
    localparam int c_ptr_w  = $clog2(DEPTH);
    localparam int c_cnt_w  = c_ptr_w + 1;
    localparam int c_word_w = DWIDTH * PACK;
    localparam int c_ent_w  = c_word_w + PACK + 1;
    localparam logic [c_lane_w-1:0] c_last_lane = c_lane_w'(PACK - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_done_nxt;
    logic                  r_done;
    logic                  r_ovf;

    logic [LEN_W-1:0]      r_remain;
    logic [c_lane_w-1:0]   r_lane;
    logic [c_word_w-1:0]   r_acc;

    logic                  w_start_ok;
    logic                  w_beat;
    logic                  w_rem_one;
    logic                  w_push;
    logic                  w_last_beat;
    logic [c_word_w-1:0]   w_word;
    logic [PACK-1:0]       w_keep;

    logic [c_ent_w-1:0]    r_mem [DEPTH];
    logic [c_ent_w-1:0]    w_head;
    logic [c_cnt_w-1:0]    r_wptr;
    logic [c_cnt_w-1:0]    r_rptr;
    logic [c_cnt_w-1:0]    w_count;
    logic [c_cnt_w-1:0]    w_count_nxt;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_pop;
    logic                  w_wr;
    logic                  w_ovf_set;

    assign w_start_ok  = (r_state == ST_IDLE) && i_start && (i_len != '0);
    assign w_beat      = (r_state == ST_RUN) && i_bwd_vld;
    assign w_rem_one   = (r_remain == LEN_W'(1));
    assign w_push      = w_beat && ((r_lane == c_last_lane) || w_rem_one);
    assign w_last_beat = w_beat && w_rem_one;

    // Lanes below the current index come from the accumulator, the current
    // lane takes the incoming beat, and lanes above it read zero.
    for (genvar gi = 0; gi < PACK; gi++) begin : g_lane
        localparam logic [c_lane_w-1:0] c_idx = c_lane_w'(gi);
        if (gi == 0) begin : g_first
            assign w_keep[gi] = 1'b1;
        end else begin : g_rest
            assign w_keep[gi] = (r_lane >= c_idx);
        end
        assign w_word[gi*DWIDTH +: DWIDTH] =
            (r_lane == c_idx) ? i_bwd_dat :
            w_keep[gi]        ? r_acc[gi*DWIDTH +: DWIDTH] : '0;
    end

    assign w_count     = r_wptr - r_rptr;
    assign w_empty     = (r_wptr == r_rptr);
    assign w_full      = (r_wptr[c_ptr_w] != r_rptr[c_ptr_w]) &&
                         (r_wptr[c_ptr_w-1:0] == r_rptr[c_ptr_w-1:0]);
    assign w_pop       = !w_empty && i_rdy;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign w_wr        = w_push && (!w_full || w_pop);
    assign w_ovf_set   = w_push && w_full && !w_pop;
    assign w_count_nxt = w_count + c_cnt_w'(w_wr) - c_cnt_w'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    if (i_len != '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (w_last_beat) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Finish on the edge that leaves the FIFO empty.
                if (w_count_nxt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge aixh_core_clk2x or negedge aixh_core_rstn) begin
        if (!aixh_core_rstn) begin
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
            r_remain <= '0;
            r_lane   <= '0;
            r_acc    <= '0;
            r_wptr   <= '0;
            r_rptr   <= '0;
        end else begin
            r_done <= w_done_nxt;
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
            if (w_wr) begin
                r_wptr <= r_wptr + c_cnt_w'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_cnt_w'(1);
            end
            if (w_start_ok) begin
                r_remain <= i_len;
                r_lane   <= '0;
                r_acc    <= '0;
            end else if (w_beat) begin
                if (r_remain != '0) begin
                    r_remain <= r_remain - LEN_W'(1);
                end
                r_lane <= r_lane + c_lane_w'(1);
                r_acc  <= w_push ? '0 : w_word;
            end
        end
    end

    always_ff @(posedge aixh_core_clk2x) begin
        if (w_wr) begin
            r_mem[r_wptr[c_ptr_w-1:0]] <= {w_last_beat, w_keep, w_word};
        end
    end

    // Storage is not reset, so the head is masked whenever the FIFO is empty.
    assign w_head = r_mem[r_rptr[c_ptr_w-1:0]];
    assign o_vld  = !w_empty;
    assign o_dat  = w_empty ? '0 : w_head[c_word_w-1:0];
    assign o_keep = w_empty ? '0 : w_head[c_word_w +: PACK];
    assign o_last = w_empty ? 1'b0 : w_head[c_ent_w-1];
    assign o_busy = (r_state != ST_IDLE);
    assign o_done = r_done;
    assign o_ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_aixh_mxc_upper_bwd_packer.sv
`default_nettype none
//============================================================================
// Module      : tb_aixh_mxc_upper_bwd_packer
// Description : Scoreboard bench for the backward-beat packer.
// Revision    : 1.0 - initial release
//============================================================================
module tb_aixh_mxc_upper_bwd_packer;

    localparam int DW = 64;
    localparam int PK = 4;
    localparam int DP = 8;
    localparam int LW = 16;
    localparam int WW = DW * PK;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_start = 1'b0;
    logic [LW-1:0] i_len = '0;
    logic          o_busy;
    logic          o_done;
    logic          i_bwd_vld = 1'b0;
    logic [DW-1:0] i_bwd_dat = '0;
    logic          o_vld;
    logic          i_rdy = 1'b1;
    logic [WW-1:0] o_dat;
    logic [PK-1:0] o_keep;
    logic          o_last;
    logic          o_ovf;
    logic          i_clr_ovf = 1'b0;

    typedef struct {
        logic [WW-1:0] dat;
        logic [PK-1:0] keep;
        logic          last;
    } word_t;

    word_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    always #5 clk = ~clk;

    aixh_mxc_upper_bwd_packer #(
        .DWIDTH (DW),
        .PACK   (PK),
        .DEPTH  (DP),
        .LEN_W  (LW)
    ) dut (
        .aixh_core_clk2x (clk),
        .aixh_core_rstn  (rst_n),
        .i_start         (i_start),
        .i_len           (i_len),
        .o_busy          (o_busy),
        .o_done          (o_done),
        .i_bwd_vld       (i_bwd_vld),
        .i_bwd_dat       (i_bwd_dat),
        .o_vld           (o_vld),
        .i_rdy           (i_rdy),
        .o_dat           (o_dat),
        .o_keep          (o_keep),
        .o_last          (o_last),
        .o_ovf           (o_ovf),
        .i_clr_ovf       (i_clr_ovf)
    );

    // Expected word: beats first..first+n-1 in lanes 0..n-1, rest zero.
    function automatic logic [WW-1:0] mkword(input int first, input int n);
        logic [WW-1:0] w;
        w = '0;
        for (int i = 0; i < n; i++) w[i*DW +: DW] = DW'(first + i);
        return w;
    endfunction

    task automatic push_exp(input int first, input int n, input logic last);
        word_t w;
        w.dat  = mkword(first, n);
        w.keep = PK'((1 << n) - 1);
        w.last = last;
        sb.push_back(w);
    endtask

    task automatic start_frame(input int len);
        @(posedge clk); #1;
        i_start = 1'b1;
        i_len   = LW'(len);
    endtask

    task automatic drive_beats(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            i_start   = 1'b0;
            i_bwd_vld = 1'b1;
            i_bwd_dat = DW'(first + k);
        end
        @(posedge clk); #1;
        i_start   = 1'b0;
        i_bwd_vld = 1'b0;
    endtask

    // Pops the scoreboard on every accepted word for a bounded window and
    // checks that o_done pulses once, in the cycle after the final pop.
    task automatic monitor(input int cycles, input bit exp_done);
        word_t e;
        int    pop_cyc  = -1;
        int    done_cyc = -1;
        int    n_done   = 0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (o_done) begin
                n_done++;
                done_cyc = c;
            end
            if (o_vld && i_rdy) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got dat=%h keep=%b last=%b, required no word",
                             o_dat, o_keep, o_last);
                end else begin
                    e = sb.pop_front();
                    if (o_dat !== e.dat || o_keep !== e.keep || o_last !== e.last) begin
                        n_fail++;
                        $display("FAIL sb_word: got dat=%h keep=%b last=%b, required dat=%h keep=%b last=%b",
                                 o_dat, o_keep, o_last, e.dat, e.keep, e.last);
                    end
                end
                pop_cyc = c;
            end
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_missing: got %0d words outstanding, required 0", sb.size());
            sb.delete();
        end
        if (exp_done) begin
            n_tests++;
            if (n_done !== 1 || done_cyc !== pop_cyc + 1) begin
                n_fail++;
                $display("FAIL done_pulse: got %0d pulses at cycle %0d, required 1 at cycle %0d",
                         n_done, done_cyc, pop_cyc + 1);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if ({o_vld, o_dat, o_keep, o_last, o_busy, o_done, o_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: got vld=%b keep=%b last=%b busy=%b done=%b ovf=%b, required all 0",
                     o_vld, o_keep, o_last, o_busy, o_done, o_ovf);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({o_vld, o_dat, o_keep, o_last, o_busy, o_done, o_ovf} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: got vld=%b busy=%b done=%b ovf=%b, required all 0",
                     o_vld, o_busy, o_done, o_ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        i_rdy = 1'b1;
        push_exp(1, 4, 1'b0);
        push_exp(5, 4, 1'b1);
        fork
            begin
                start_frame(8);
                for (int k = 1; k <= 8; k++) begin
                    @(posedge clk); #1;
                    i_start   = 1'b0;
                    i_bwd_vld = 1'b1;
                    i_bwd_dat = DW'(k);
                    @(negedge clk);
                    n_tests++;
                    if (o_vld !== (k == 5) || o_busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL basic_latency: beat %0d got vld=%b busy=%b, required vld=%b busy=1",
                                 k, o_vld, o_busy, (k == 5));
                    end
                end
                @(posedge clk); #1;
                i_bwd_vld = 1'b0;
                @(negedge clk);
                n_tests++;
                if (o_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_word2_vld: got %b, required 1", o_vld);
                end
            end
            monitor(30, 1'b1);
        join
    endtask

    task automatic test_partial();
        i_rdy = 1'b1;
        @(posedge clk); #1;
        i_bwd_vld = 1'b1;
        i_bwd_dat = DW'(64'hdead);
        @(posedge clk); #1;
        i_bwd_vld = 1'b0;
        push_exp(1, 4, 1'b0);
        push_exp(5, 2, 1'b1);
        fork
            begin
                start_frame(6);
                // Beat 3 carries a stray start; beat 7 lands in DRAIN.
                for (int k = 1; k <= 7; k++) begin
                    @(posedge clk); #1;
                    i_start   = (k == 3);
                    i_len     = (k == 3) ? LW'(2) : LW'(6);
                    i_bwd_vld = 1'b1;
                    i_bwd_dat = (k == 7) ? DW'(64'hbeef) : DW'(k);
                end
                @(posedge clk); #1;
                i_start   = 1'b0;
                i_bwd_vld = 1'b0;
            end
            monitor(30, 1'b1);
        join
    endtask

    task automatic test_zero_len();
        start_frame(0);
        @(posedge clk); #1;
        i_start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_tests++;
            if (o_done !== (c == 0) || o_vld !== 1'b0 || o_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL zero_len: cycle %0d got done=%b vld=%b busy=%b, required done=%b vld=0 busy=0",
                         c, o_done, o_vld, o_busy, (c == 0));
            end
        end
    endtask

    task automatic test_full_pop();
        i_rdy = 1'b0;
        for (int j = 0; j < 9; j++) push_exp(1 + 4 * j, 4, (j == 8));
        fork
            begin
                start_frame(36);
                for (int k = 1; k <= 36; k++) begin
                    @(posedge clk); #1;
                    i_start   = 1'b0;
                    i_bwd_vld = 1'b1;
                    i_bwd_dat = DW'(k);
                    if (k == 36) i_rdy = 1'b1;
                    if (k == 34) begin
                        @(negedge clk);
                        n_tests++;
                        if (o_vld !== 1'b1 || o_dat !== mkword(1, 4) || o_keep !== 4'hF) begin
                            n_fail++;
                            $display("FAIL full_hold: got vld=%b dat=%h keep=%b, required vld=1 dat=%h keep=1111",
                                     o_vld, o_dat, o_keep, mkword(1, 4));
                        end
                    end
                end
                @(posedge clk); #1;
                i_bwd_vld = 1'b0;
                @(negedge clk);
                n_tests++;
                if (o_ovf !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_pop_ovf: got %b, required 0", o_ovf);
                end
            end
            monitor(60, 1'b1);
        join
    endtask

    task automatic test_overflow();
        i_rdy = 1'b0;
        for (int j = 0; j < 8; j++) push_exp(1 + 4 * j, 4, 1'b0);
        fork
            begin
                start_frame(40);
                for (int k = 1; k <= 40; k++) begin
                    @(posedge clk); #1;
                    i_start   = 1'b0;
                    i_bwd_vld = 1'b1;
                    i_bwd_dat = DW'(k);
                    if (k == 33 || k == 37) begin
                        @(negedge clk);
                        n_tests++;
                        if (o_ovf !== (k == 37)) begin
                            n_fail++;
                            $display("FAIL ovf_set: beat %0d got %b, required %b", k, o_ovf, (k == 37));
                        end
                    end
                end
                @(posedge clk); #1;
                i_bwd_vld = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                n_tests++;
                if (o_busy !== 1'b1 || o_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL ovf_drain_wait: got busy=%b vld=%b, required 1 1", o_busy, o_vld);
                end
                @(posedge clk); #1;
                i_rdy = 1'b1;
            end
            monitor(70, 1'b1);
        join
        @(negedge clk);
        n_tests++;
        if (o_ovf !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_sticky: got ovf=%b busy=%b, required ovf=1 busy=0", o_ovf, o_busy);
        end
    endtask

    task automatic test_reset_midframe();
        i_rdy = 1'b1;
        start_frame(8);
        drive_beats(100, 3);
        n_tests++;
        if (o_busy !== 1'b1 || o_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL midframe_pre: got busy=%b ovf=%b, required 1 1", o_busy, o_ovf);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_vld, o_dat, o_keep, o_last, o_busy, o_done, o_ovf} !== '0) begin
            n_fail++;
            $display("FAIL midframe_reset: got vld=%b busy=%b done=%b ovf=%b, required all 0",
                     o_vld, o_busy, o_done, o_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push_exp(1, 4, 1'b1);
        fork
            begin
                start_frame(4);
                drive_beats(1, 4);
            end
            monitor(20, 1'b1);
        join
    endtask

    task automatic test_set_wins();
        i_rdy = 1'b0;
        for (int j = 0; j < 8; j++) push_exp(1 + 4 * j, 4, 1'b0);
        fork
            begin
                start_frame(36);
                for (int k = 1; k <= 36; k++) begin
                    @(posedge clk); #1;
                    i_start   = 1'b0;
                    i_bwd_vld = 1'b1;
                    i_bwd_dat = DW'(k);
                    i_clr_ovf = (k == 36);
                end
                @(posedge clk); #1;
                i_bwd_vld = 1'b0;
                i_clr_ovf = 1'b0;
                @(negedge clk);
                n_tests++;
                if (o_ovf !== 1'b1) begin
                    n_fail++;
                    $display("FAIL set_wins: got %b, required 1", o_ovf);
                end
                @(posedge clk); #1;
                i_rdy = 1'b1;
            end
            monitor(60, 1'b1);
        join
        @(posedge clk); #1;
        i_clr_ovf = 1'b1;
        @(posedge clk); #1;
        i_clr_ovf = 1'b0;
        @(negedge clk);
        n_tests++;
        if (o_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: got %b, required 0", o_ovf);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_zero_len();
        test_full_pop();
        test_overflow();
        test_reset_midframe();
        test_set_wins();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
